// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
//   Holds the PC, issues one request at a time to instruction memory over a
//   ready/valid handshake, and presents each fetched instruction with its PC
//   and PC+4. A one-entry skid buffer absorbs decode stalls. Redirects from
//   PCSrc/JumpPRT flush the output and discard any wrong-path response.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   PCSrc, JumpPRT               redirect request / register-based target
//   PCE, ImmExt, ALUResult       redirect target operands
//   stall                        decode cannot accept a new instruction
//   imem_req, imem_addr          request valid / address
//   imem_ready                   memory accepts the request
//   imem_rvalid, imem_rdata      response pulse / instruction
//   instr_valid, instr           fetched instruction and its valid
//   pc_out, pc_plus4             PC of instr and its link value
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic        JumpPRT,
  input  logic [31:0] PCE,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        drop;
  logic [31:0] target;
  logic        handshake;

  assign target    = JumpPRT ? {ALUResult[31:1], 1'b0} : PCE + ImmExt;
  assign imem_req  = (state == S_REQ) && !PCSrc;
  assign imem_addr = pc;
  assign handshake = imem_req && imem_ready;
  assign pc_plus4  = pc_out + 32'd4;

  // The skid buffer holds a live entry exactly while in S_FULL, so leaving
  // S_FULL is what invalidates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      req_pc      <= '0;
      drop        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP;
      pc_out      <= '0;
      skid_instr  <= '0;
      skid_pc     <= '0;
    end else if (PCSrc) begin
      pc          <= target;
      instr_valid <= 1'b0;
      instr       <= NOP;
      case (state)
        S_WAIT: begin
          // A response in the same cycle is the wrong-path one: drop it now;
          // otherwise remember to drop it when it arrives.
          if (imem_rvalid) begin
            state <= S_REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= S_WAIT;
          end
          if (!stall) begin
            instr_valid <= 1'b0;
            instr       <= NOP;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state <= S_REQ;
            if (drop) begin
              drop <= 1'b0;
              if (!stall) begin
                instr_valid <= 1'b0;
                instr       <= NOP;
              end
            end else if (!instr_valid || !stall) begin
              instr       <= imem_rdata;
              pc_out      <= req_pc;
              instr_valid <= 1'b1;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= req_pc;
              state      <= S_FULL;
            end
          end else if (!stall) begin
            instr_valid <= 1'b0;
            instr       <= NOP;
          end
        end
        S_FULL: begin
          if (!stall) begin
            instr  <= skid_instr;
            pc_out <= skid_pc;
            state  <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The reference model views the unit at
// the transaction level: a queue of instructions owed to decode (pushed when
// a right-path response returns, popped when decode consumes, flushed on
// redirect), the expected next fetch address, and whether a request is in
// flight. A simple memory model answers requests with a per-address word.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC00000;
  localparam logic [31:0] NOPV   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, PCSrc, JumpPRT, stall;
  logic [31:0] PCE, ImmExt, ALUResult;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, pc_out, pc_plus4;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .NOP(NOPV)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .JumpPRT(JumpPRT), .PCE(PCE),
    .ImmExt(ImmExt), .ALUResult(ALUResult), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out),
    .pc_plus4(pc_plus4)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference model state
  ent_t        q[$];
  logic [31:0] exp_pc;
  bit          outstanding, killed, chk_en;
  logic        exp_req, hs;
  logic [31:0] tgt;

  // memory model state
  bit          mem_pend, mem_hs;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_fix;
  bit          lat_rand, rdy_rand;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task step();
    imem_rvalid = mem_pend && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
    imem_ready  = !mem_pend && (rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1);
    #1;
    exp_req = !outstanding && (q.size() < 2) && !PCSrc;
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, exp_pc);
      chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("instr", instr, q[0].ins);
        chk("pc_out", pc_out, q[0].pc);
        chk("pc_plus4", pc_plus4, q[0].pc + 32'd4);
      end else begin
        chk("instr_nop", instr, NOPV);
      end
    end
    hs     = exp_req && imem_ready;
    mem_hs = (imem_req === 1'b1) && imem_ready;
    tgt    = JumpPRT ? {ALUResult[31:1], 1'b0} : PCE + ImmExt;
    @(posedge clk);
    if (rst) begin
      q.delete();
      outstanding = 0;
      killed      = 0;
      exp_pc      = RST_PC;
    end else begin
      bit resp_ok;
      resp_ok = 0;
      if (imem_rvalid && outstanding) begin
        outstanding = 0;
        resp_ok     = !killed && !PCSrc;
      end
      if (PCSrc) begin
        q.delete();
        if (outstanding) killed = 1;
        exp_pc = tgt;
      end else begin
        if (q.size() != 0 && !stall) void'(q.pop_front());
        if (resp_ok) q.push_back('{ins: mem_word(mem_addr), pc: mem_addr});
      end
      if (hs) begin
        outstanding = 1;
        killed      = 0;
        exp_pc      = exp_pc + 32'd4;
      end
    end
    if (mem_pend) begin
      if (imem_rvalid) mem_pend = 0;
      else mem_cnt--;
    end
    if (mem_hs) begin
      mem_pend = 1;
      mem_addr = imem_addr;
      mem_cnt  = lat_rand ? $urandom_range(0, 3) : lat_fix;
    end
    @(negedge clk);
  endtask

  task do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; PCSrc = 1'b0; JumpPRT = 1'b0; stall = 1'b0;
    PCE = '0; ImmExt = '0; ALUResult = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    exp_pc = RST_PC; outstanding = 0; killed = 0; chk_en = 0;
    mem_pend = 0; mem_cnt = 0; mem_addr = '0;
    lat_fix = 0; lat_rand = 0; rdy_rand = 0;

    // reset and first fetch
    @(negedge clk);
    step();
    chk_en = 1;
    step();
    rst = 1'b0;
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOPV);
    chk("rst_pc_out", pc_out, 32'd0);
    step();
    step();
    chk("first_instr", instr, 32'h00500093);
    chk("first_pc", pc_out, RST_PC);
    chk("first_pc4", pc_plus4, 32'hBFC00004);

    // streaming with zero-wait memory
    for (int k = 1; k < 4; k++) begin
      chk("stream_addr", imem_addr, RST_PC + 32'(4 * k));
      step();
      step();
      chk("stream_pc", pc_out, RST_PC + 32'(4 * k));
      chk("stream_valid", 32'(instr_valid), 32'd1);
    end

    // stall and skid
    do_reset(2);
    step();
    step();
    stall = 1'b1;
    step();
    step();
    chk("skid_req", 32'(imem_req), 32'd0);
    chk("skid_hold", pc_out, RST_PC);
    step();
    chk("skid_req2", 32'(imem_req), 32'd0);
    stall = 1'b0;
    step();
    chk("skid_out", pc_out, 32'hBFC00004);
    chk("skid_next", imem_addr, 32'hBFC00008);
    chk("skid_nreq", 32'(imem_req), 32'd1);

    // redirect while waiting, late response dropped
    do_reset(2);
    lat_fix = 2;
    step();
    PCSrc = 1'b1; JumpPRT = 1'b0; PCE = 32'hBFC00010; ImmExt = 32'hFFFFFFF8;
    step();
    PCSrc = 1'b0;
    step();
    step();
    chk("redir_valid", 32'(instr_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'hBFC00008);

    // JALR redirect coinciding with the response
    do_reset(2);
    lat_fix = 0;
    step();
    PCSrc = 1'b1; JumpPRT = 1'b1; ALUResult = 32'hBFC00025;
    step();
    PCSrc = 1'b0; JumpPRT = 1'b0;
    chk("jalr_addr", imem_addr, 32'hBFC00024);
    chk("jalr_valid", 32'(instr_valid), 32'd0);

    // reset mid-WAIT with the response arriving during reset
    do_reset(2);
    lat_fix = 1;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rstw_valid", 32'(instr_valid), 32'd0);
    chk("rstw_addr", imem_addr, RST_PC);

    // stale response arriving after reset while in REQ
    do_reset(2);
    lat_fix = 3;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("stale_valid", 32'(instr_valid), 32'd0);

    // randomized traffic
    lat_rand = 1;
    rdy_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      stall     = 1'($urandom_range(0, 1));
      PCSrc     = ($urandom_range(0, 9) == 0);
      JumpPRT   = 1'($urandom_range(0, 1));
      PCE       = $urandom;
      ImmExt    = $urandom;
      ALUResult = $urandom;
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; PCSrc = 1'b0; stall = 1'b0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage upstream of the control unit. Holds the PC, issues one-at-a-time requests to instruction memory over a ready/valid handshake, and presents each fetched instruction with its PC and PC+4 to decode, which feeds `op`, `funct3` and `funct7` to the control unit. It absorbs decode stalls with a one-entry skid buffer and applies redirects from `PCSrc`/`JumpPRT`, discarding any wrong-path response.

## Interface
- `RESET_PC`, default 32'hBFC00000: PC loaded on reset.
- `NOP`, default 32'h00000013: value `instr` is driven to when no instruction is valid.
- `clk  in  1`: clock; all state changes on the rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `PCSrc  in  1`: redirect request this cycle, from the control unit.
- `JumpPRT  in  1`: redirect target is register-based (JALR).
- `PCE  in  32`: PC of the redirecting instruction.
- `ImmExt  in  32`: immediate of the redirecting instruction.
- `ALUResult  in  32`: JALR target, rs1 + imm.
- `stall  in  1`: decode cannot accept a new instruction.
- `imem_req  out  1`: request valid.
- `imem_addr  out  32`: request address.
- `imem_ready  in  1`: memory accepts the request this cycle.
- `imem_rvalid  in  1`: response valid, one-cycle pulse, cannot be back-pressured.
- `imem_rdata  in  32`: response instruction.
- `instr_valid  out  1`: `instr`, `pc_out` and `pc_plus4` are valid.
- `instr  out  32`: fetched instruction.
- `pc_out  out  32`: PC of `instr`.
- `pc_plus4  out  32`: `pc_out` + 4, the JAL/JALR link value.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `req_pc`: address of the outstanding request.
  - Output register: `instr`, `pc_out`, `instr_valid`.
  - Skid buffer: instruction plus PC.
  - `drop` flag.
  - FSM state.
- States:
  - **REQ**: `imem_req` = !`PCSrc`, `imem_addr` = `pc`. On handshake (`imem_req` && `imem_ready`): `req_pc` <= `pc`, `pc` <= `pc` + 4, go to WAIT.
  - **WAIT**: no request. On `imem_rvalid`:
    - If `drop`: discard the response, clear `drop`, go to REQ.
    - Else if `instr_valid`==0 or `stall`==0: load the output register with {`imem_rdata`, `req_pc`} and set `instr_valid`; go to REQ.
    - Else: load the skid buffer; go to FULL.
  - **FULL**: output held. When `stall`==0, move skid to output (`instr_valid` stays 1) and go to REQ.
- Output consumption: in REQ or WAIT, if `stall`==0 and nothing new is loaded this cycle, `instr_valid` <= 0 and `instr` <= `NOP`.
- Redirect (`PCSrc`=1), which overrides stall handling in every state:
  - Target = `JumpPRT` ? {`ALUResult`[31:1], 1'b0} : `PCE` + `ImmExt` (32-bit wrap, no overflow detection).
  - `pc` <= target; `instr_valid` <= 0; `instr` <= `NOP`; skid buffer invalidated.
  - REQ: no handshake this cycle (`imem_req` is low); stay in REQ.
  - WAIT without `imem_rvalid`: set `drop`; stay in WAIT.
  - WAIT with `imem_rvalid` the same cycle: discard the response; go to REQ.
  - FULL: go to REQ.
- `pc_plus4` is combinational: `pc_out` + 4.
- No alignment check. Bits [1:0] of `pc` are passed through unchanged.

## Timing
- Reset values, one cycle after `rst` is sampled high:
  - `pc`=`RESET_PC`, state=REQ, `drop`=0.
  - `instr_valid`=0, `instr`=`NOP`, `pc_out`=0.
  - Skid buffer empty.
  - `imem_req`=1 with `imem_addr`=`RESET_PC` in the first cycle after `rst` deasserts.
- Reset mid-operation discards all state, including any outstanding request. A response arriving after reset while in REQ is ignored.
- Latency:
  - Handshake at edge t, `imem_rvalid` in cycle t+k: `instr_valid` is high from edge t+k+1.
  - Zero-wait memory gives 1 instruction per 2 cycles.
- Redirect sampled at edge t: `instr_valid`=0 after t. The first request to the target is issued in cycle t+1, or after the dropped response returns.
- At most one outstanding request. No request is issued from WAIT or FULL.
- `imem_req` is deasserted combinationally in any cycle with `PCSrc`=1.

## Test plan
- **Reset and first fetch**: hold `rst` 2 cycles, `imem_ready`=1, `rvalid` 1 cycle after handshake, data 32'h00500093 → `imem_addr`=BFC00000. Two cycles later `instr`=00500093, `pc_out`=BFC00000, `pc_plus4`=BFC00004.
- **Streaming**: zero-wait memory, 4 instructions → addresses BFC00000/04/08/0C. `instr_valid` rises every 2 cycles, each `pc_out` matches its address.
- **Stall and skid**: `stall`=1 with the output valid while a response for BFC00004 arrives → FULL, no new `imem_req`, output still holds BFC00000. Release `stall` → output becomes BFC00004, next request goes to BFC00008.
- **Redirect while waiting**: `PCSrc`=1, `JumpPRT`=0, `PCE`=BFC00010, `ImmExt`=32'hFFFFFFF8, during WAIT. The late response is discarded, `instr_valid` stays 0, and the next `imem_addr`=BFC00008.
- **JALR target**: `PCSrc`=1, `JumpPRT`=1, `ALUResult`=BFC00025, with `rvalid` in the same cycle → that response is discarded, next `imem_addr`=BFC00024.
- **Reset mid-WAIT**: assert `rst` during WAIT → `instr_valid`=0, `imem_addr`=BFC00000. A response arriving during `rst` is ignored.
